// File: rtl/instruction_fetch_unit.sv
// Fetch stage of the 16-bit accumulator processor: PC, single-outstanding
// instruction read, small prefetch FIFO presenting the head word as IR.
`timescale 1ns/1ps
module instruction_fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 16,
    parameter int                DEPTH    = 2,
    parameter int                PC_STEP  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               CLK,
    input  logic               Reset,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_rvalid,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               PCWrite,
    input  logic [ADDR_W-1:0]  PCIn,
    output logic [INSTR_W-1:0] IR,
    output logic [ADDR_W-1:0]  IR_PC,
    output logic               IR_valid,
    input  logic               IR_ready,
    output logic [1:0]         dbg_state
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [INSTR_W-1:0] fifo_data_q [DEPTH];
    logic [ADDR_W-1:0]  fifo_addr_q [DEPTH];

    logic has_space;
    logic push;
    logic pop;
    logic head_valid;

    // Space check deliberately ignores a same-cycle pop.
    assign has_space  = (count_q < CNT_W'(DEPTH));
    assign head_valid = !Reset && (count_q != '0);
    assign pop        = head_valid && IR_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        mem_req    = 1'b0;
        push       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (PCWrite) begin
                    pc_d = PCIn;
                end else if (has_space && !Reset) begin
                    mem_req    = 1'b1;
                    req_addr_d = pc_q;
                    pc_d       = pc_q + ADDR_W'(PC_STEP);
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (PCWrite) begin
                    // A response arriving with the redirect completes the read, so no drain is needed.
                    pc_d    = PCIn;
                    state_d = mem_rvalid ? S_IDLE : S_DRAIN;
                end else if (mem_rvalid) begin
                    push    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (PCWrite) begin
                    pc_d = PCIn;
                end
                if (mem_rvalid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (PCWrite) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: the head is only visible when count is non-zero.
    always_ff @(posedge CLK) begin
        if (push && !Reset) begin
            fifo_data_q[wr_ptr_q] <= mem_rdata;
            fifo_addr_q[wr_ptr_q] <= req_addr_q;
        end
    end

    assign mem_addr  = pc_q;
    assign IR_valid  = head_valid;
    assign IR        = head_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign IR_PC     = head_valid ? fifo_addr_q[rd_ptr_q] : '0;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: cycle-stepped memory model,
// address/ordering scoreboard and a second instance reset to 16'hFFFE.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;
    logic        CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        Reset      = 1'b1;
    logic        PCWrite    = 1'b0;
    logic [15:0] PCIn       = '0;
    logic        IR_ready   = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [15:0] mem_rdata  = '0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] IR;
    logic [15:0] IR_PC;
    logic        IR_valid;
    logic [1:0]  dbg_state;

    logic        pcwrite2  = 1'b0;
    logic [15:0] pcin2     = '0;
    logic        ir_ready2 = 1'b1;
    logic        rvalid2   = 1'b0;
    logic [15:0] rdata2    = 16'h0000;
    logic        mem_req2;
    logic [15:0] mem_addr2;
    logic [15:0] ir2;
    logic [15:0] ir_pc2;
    logic        ir_valid2;
    logic [1:0]  dbg_state2;

    instruction_fetch_unit dut (
        .CLK(CLK), .Reset(Reset),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .PCWrite(PCWrite), .PCIn(PCIn),
        .IR(IR), .IR_PC(IR_PC), .IR_valid(IR_valid), .IR_ready(IR_ready),
        .dbg_state(dbg_state)
    );

    instruction_fetch_unit #(.RESET_PC(16'hFFFE)) dut_wrap (
        .CLK(CLK), .Reset(Reset),
        .mem_req(mem_req2), .mem_addr(mem_addr2),
        .mem_rvalid(rvalid2), .mem_rdata(rdata2),
        .PCWrite(pcwrite2), .PCIn(pcin2),
        .IR(ir2), .IR_PC(ir_pc2), .IR_valid(ir_valid2), .IR_ready(ir_ready2),
        .dbg_state(dbg_state2)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          pops     = 0;
    int          n_req2   = 0;
    int          lat      = 1;
    int          pend_cnt = 0;
    logic [15:0] pend_addr = '0;
    logic [15:0] exp_pc   = 16'h0000;
    logic [15:0] exp_pc2  = 16'hFFFE;
    logic        req2_seen = 1'b0;
    logic [31:0] exp_q[$];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0000: mem_word = 16'h0088;
            16'h0002: mem_word = 16'h1234;
            default:  mem_word = a ^ 16'hA5C3;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // One clock cycle: check this cycle's outputs, then advance and drive memory responses.
    task automatic cycle();
        logic [31:0] e;
        #1;
        if (Reset) begin
            chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
            chk("rst_ir_valid", {31'd0, IR_valid}, 32'd0);
            chk("rst_ir", {16'd0, IR}, 32'd0);
            chk("rst_ir_pc", {16'd0, IR_PC}, 32'd0);
            chk("rst_ir_valid2", {31'd0, ir_valid2}, 32'd0);
            exp_q.delete();
            exp_pc    = 16'h0000;
            exp_pc2   = 16'hFFFE;
            req2_seen = 1'b0;
        end else begin
            if (mem_req) begin
                chk("mem_addr", {16'd0, mem_addr}, {16'd0, exp_pc});
                exp_q.push_back({mem_word(exp_pc), exp_pc});
                pend_cnt  = lat;
                pend_addr = mem_addr;
                exp_pc    = exp_pc + 16'd2;
            end
            if (PCWrite) chk("no_req_on_redirect", {31'd0, mem_req}, 32'd0);
            if (!IR_valid) chk("ir_zero_when_empty", {16'd0, IR}, 32'd0);
            if (IR_valid && IR_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", {16'd0, IR_PC}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_ir", {16'd0, IR}, {16'd0, e[31:16]});
                    chk("pop_ir_pc", {16'd0, IR_PC}, {16'd0, e[15:0]});
                end
                pops++;
            end
            if (PCWrite) begin
                exp_q.delete();
                exp_pc = PCIn;
            end
            if (mem_req2) begin
                chk("wrap_mem_addr", {16'd0, mem_addr2}, {16'd0, exp_pc2});
                exp_pc2 = exp_pc2 + 16'd2;
                n_req2++;
            end
            req2_seen = mem_req2;
        end
        @(posedge CLK);
        #1;
        mem_rvalid = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word(pend_addr);
            end
        end
        rvalid2 = req2_seen;
    endtask

    task automatic do_reset(input int l, input logic rdy);
        Reset    = 1'b1;
        PCWrite  = 1'b0;
        lat      = l;
        IR_ready = rdy;
        repeat (2) cycle();
        Reset = 1'b0;
    endtask

    initial begin
        int p0;
        // Test 1 + wrap instance: 1-cycle memory, decode always ready.
        do_reset(1, 1'b1);
        settle();
        chk("t1_first_req", {31'd0, mem_req}, 32'd1);
        chk("t1_first_addr", {16'd0, mem_addr}, 32'h0000);
        chk("t5_first_addr", {16'd0, mem_addr2}, 32'hFFFE);
        cycle();
        chk("t1_ir_valid_c1", {31'd0, IR_valid}, 32'd0);
        cycle();
        chk("t1_ir_valid_c2", {31'd0, IR_valid}, 32'd1);
        chk("t1_ir_c2", {16'd0, IR}, 32'h0088);
        chk("t1_ir_pc_c2", {16'd0, IR_PC}, 32'h0000);
        chk("t5_wrap_req", {31'd0, mem_req2}, 32'd1);
        chk("t5_wrap_addr", {16'd0, mem_addr2}, 32'h0000);
        cycle();
        cycle();
        chk("t1_ir_c4", {16'd0, IR}, 32'h1234);
        chk("t1_ir_pc_c4", {16'd0, IR_PC}, 32'h0002);
        p0 = pops;
        repeat (10) cycle();
        chk("t1_throughput", (pops - p0) >= 4 ? 32'd1 : 32'd0, 32'd1);
        chk("t5_req_count", n_req2 >= 2 ? 32'd1 : 32'd0, 32'd1);

        // Test 2: decode stalled, FIFO fills, then resumes at 4.
        do_reset(1, 1'b0);
        repeat (8) cycle();
        chk("t2_no_req_full", {31'd0, mem_req}, 32'd0);
        chk("t2_ir_valid", {31'd0, IR_valid}, 32'd1);
        chk("t2_ir", {16'd0, IR}, 32'h0088);
        chk("t2_ir_pc", {16'd0, IR_PC}, 32'h0000);
        IR_ready = 1'b1;
        settle();
        chk("t2_no_bypass", {31'd0, mem_req}, 32'd0);
        cycle();
        chk("t2_resume_req", {31'd0, mem_req}, 32'd1);
        chk("t2_resume_addr", {16'd0, mem_addr}, 32'h0004);
        p0 = pops;
        repeat (8) cycle();
        chk("t2_pops", (pops - p0) >= 4 ? 32'd1 : 32'd0, 32'd1);

        // Test 3: 3-cycle memory, redirect while waiting.
        do_reset(3, 1'b1);
        cycle();
        PCWrite = 1'b1;
        PCIn    = 16'h0040;
        cycle();
        PCWrite = 1'b0;
        settle();
        chk("t3_drain_state", {30'd0, dbg_state}, 32'd2);
        chk("t3_drain_ir_valid", {31'd0, IR_valid}, 32'd0);
        chk("t3_drain_no_req", {31'd0, mem_req}, 32'd0);
        cycle();
        chk("t3_stale_ir_valid", {31'd0, IR_valid}, 32'd0);
        cycle();
        chk("t3_target_req", {31'd0, mem_req}, 32'd1);
        chk("t3_target_addr", {16'd0, mem_addr}, 32'h0040);
        chk("t3_ir_valid_after", {31'd0, IR_valid}, 32'd0);
        repeat (4) cycle();
        chk("t3_ir_valid_new", {31'd0, IR_valid}, 32'd1);
        chk("t3_ir_pc_new", {16'd0, IR_PC}, 32'h0040);
        chk("t3_ir_new", {16'd0, IR}, 32'h0040 ^ 32'hA5C3);
        repeat (4) cycle();

        // Test 4: redirect with full FIFO and a simultaneous pop.
        do_reset(1, 1'b0);
        repeat (6) cycle();
        chk("t4_full_valid", {31'd0, IR_valid}, 32'd1);
        p0 = pops;
        IR_ready = 1'b1;
        PCWrite  = 1'b1;
        PCIn     = 16'h0100;
        cycle();
        PCWrite = 1'b0;
        settle();
        chk("t4_pop_counted", pops - p0, 32'd1);
        chk("t4_flushed", {31'd0, IR_valid}, 32'd0);
        chk("t4_target_req", {31'd0, mem_req}, 32'd1);
        chk("t4_target_addr", {16'd0, mem_addr}, 32'h0100);
        cycle();
        chk("t4_still_empty", {31'd0, IR_valid}, 32'd0);
        cycle();
        chk("t4_ir_valid_new", {31'd0, IR_valid}, 32'd1);
        chk("t4_ir_pc_new", {16'd0, IR_PC}, 32'h0100);
        repeat (6) cycle();

        // Test 6: reset during a 3-cycle read, stale data returns right after.
        do_reset(3, 1'b1);
        cycle();
        Reset = 1'b1;
        repeat (2) cycle();
        Reset = 1'b0;
        settle();
        chk("t6_stale_rvalid", {31'd0, mem_rvalid}, 32'd1);
        chk("t6_req", {31'd0, mem_req}, 32'd1);
        chk("t6_addr", {16'd0, mem_addr}, 32'h0000);
        cycle();
        chk("t6_ignored", {31'd0, IR_valid}, 32'd0);
        cycle();
        chk("t6_ignored2", {31'd0, IR_valid}, 32'd0);
        repeat (2) cycle();
        chk("t6_ir_valid", {31'd0, IR_valid}, 32'd1);
        chk("t6_ir", {16'd0, IR}, 32'h0088);
        chk("t6_ir_pc", {16'd0, IR_PC}, 32'h0000);
        repeat (4) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
